// File: rtl/frog_game_ctrl_pkg.sv
// Shared types and constants for the frog game sequencer.
// Holds the HUD state encoding, playfield geometry, the per-state control output bundle
// and the saturating score adder.
package frog_game_pkg;

  // HUD-visible state encoding; values are part of the renderer contract.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RESPAWN   = 3'd1,
    ST_PLAY      = 3'd2,
    ST_DYING     = 3'd3,
    ST_GOAL      = 3'd4,
    ST_GAME_OVER = 3'd5
  } game_state_e;

  // Playfield geometry: 32-pixel rows, frog parks at (START_X, START_Y) = row START_ROW.
  localparam int ROW_H     = 32;
  localparam int START_ROW = 14;
  localparam int START_X   = 320;
  localparam int START_Y   = 448;

  localparam int Y_W     = 10;
  localparam int ROW_W   = 4;
  localparam int LIVES_W = 3;
  localparam int SCORE_W = 14;
  localparam int LEVEL_W = 4;

  // Control outputs that depend only on the FSM state.
  typedef struct packed {
    logic frog_reset;
    logic move_enable;
    logic death_anim;
  } ctrl_out_t;

  function automatic ctrl_out_t state_outputs(game_state_e s);
    ctrl_out_t o;
    o = '0;
    case (s)
      ST_IDLE, ST_RESPAWN, ST_GAME_OVER: o.frog_reset  = 1'b1;
      ST_PLAY:                           o.move_enable = 1'b1;
      ST_DYING:                          o.death_anim  = 1'b1;
      default:                           o = '0;
    endcase
    return o;
  endfunction

  // Add in one extra bit so the carry is never lost, then clamp to the ceiling.
  function automatic logic [SCORE_W-1:0] score_add(logic [SCORE_W-1:0] score,
                                                   logic [SCORE_W-1:0] pts,
                                                   logic [SCORE_W-1:0] ceil);
    logic [SCORE_W:0] sum;
    sum = {1'b0, score} + {1'b0, pts};
    if (sum > {1'b0, ceil}) begin
      return ceil;
    end
    return sum[SCORE_W-1:0];
  endfunction

endpackage

// File: rtl/frog_game_ctrl_if.sv
// Bundle between the game sequencer and the frog / hazard / HUD blocks.
// master: the sequencer (samples frame_tick, start_btn, collision, frog_y; drives the rest).
// slave : the surrounding datapath and renderer.
interface frog_game_ctrl_if;
  import frog_game_pkg::*;

  logic               frame_tick;
  logic               start_btn;
  logic               collision;
  logic [Y_W-1:0]     frog_y;

  logic               frog_reset;
  logic               move_enable;
  logic [LIVES_W-1:0] lives;
  logic [SCORE_W-1:0] score;
  logic [LEVEL_W-1:0] level;
  logic [2:0]         game_state;
  logic               death_anim;

  modport master (
    input  frame_tick, start_btn, collision, frog_y,
    output frog_reset, move_enable, lives, score, level, game_state, death_anim
  );

  modport slave (
    output frame_tick, start_btn, collision, frog_y,
    input  frog_reset, move_enable, lives, score, level, game_state, death_anim
  );

endinterface

// File: rtl/frog_game_ctrl_frame_timer.sv
// Loadable frame down-counter with a zero flag.
// Ports: clk, reset (async high), load_i/load_val_i (load wins over tick), tick_i, zero_o.
// Counter stops at zero; zero_o is a decode of the registered count.
module frame_timer #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         tick_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load_i) begin
      // A tick coinciding with the load is dropped, so the entry frame is not counted.
      cnt_q <= load_val_i;
    end else if (tick_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/frog_game_ctrl.sv
// Game sequencer: start, respawn, death/goal timing, lives/score/level bookkeeping.
// Ports: clk, reset (async high), bus (frog_game_ctrl_if.master).
// All outputs registered; an input sampled at a clock edge shows its effect one cycle later.
module frog_game_ctrl
  import frog_game_pkg::*;
#(
  parameter int START_LIVES  = 3,
  parameter int DEATH_FRAMES = 60,
  parameter int WIN_FRAMES   = 90,
  parameter int ROW_POINTS   = 10,
  parameter int GOAL_POINTS  = 50,
  parameter int SCORE_MAX    = 9999,
  parameter int LEVEL_MAX    = 15
) (
  input  logic             clk,
  input  logic             reset,
  frog_game_ctrl_if.master bus
);

  localparam int TIMER_MAX = (DEATH_FRAMES > WIN_FRAMES) ? DEATH_FRAMES : WIN_FRAMES;
  localparam int TIMER_W   = $clog2(TIMER_MAX + 1);

  game_state_e        state_q, state_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [ROW_W-1:0]   best_row_q, best_row_d;
  logic               start_q;
  ctrl_out_t          outs_q;

  logic               start_rise;
  logic [ROW_W-1:0]   row;
  logic               timer_load;
  logic [TIMER_W-1:0] timer_val;
  logic               timer_tick;
  logic               timer_zero;
  logic               unused_y_bits;

  // 32-pixel rows: bits [8:5] are the row index, the remaining bits are within-row offset.
  assign row           = bus.frog_y[8:5];
  assign unused_y_bits = ^{bus.frog_y[9], bus.frog_y[4:0]};

  // The edge detector runs in every state so a button held through a game does not
  // count as a fresh press when GAME_OVER is reached.
  assign start_rise = bus.start_btn & ~start_q;

  // Only frames spent in DYING/GOAL are counted.
  assign timer_tick = bus.frame_tick && ((state_q == ST_DYING) || (state_q == ST_GOAL));

  frame_timer #(
    .W (TIMER_W)
  ) u_frame_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (timer_load),
    .load_val_i (timer_val),
    .tick_i     (timer_tick),
    .zero_o     (timer_zero)
  );

  always_comb begin
    state_d    = state_q;
    lives_d    = lives_q;
    score_d    = score_q;
    level_d    = level_q;
    best_row_d = best_row_q;
    timer_load = 1'b0;
    timer_val  = '0;

    case (state_q)
      ST_IDLE, ST_GAME_OVER: begin
        if (start_rise) begin
          state_d = ST_RESPAWN;
          lives_d = LIVES_W'(START_LIVES);
          score_d = '0;
          level_d = LEVEL_W'(1);
        end
      end

      ST_RESPAWN: begin
        best_row_d = ROW_W'(START_ROW);
        state_d    = ST_PLAY;
      end

      ST_PLAY: begin
        // Collision is checked first so a frog splatted on the goal row scores nothing.
        if (bus.collision) begin
          state_d    = ST_DYING;
          timer_load = 1'b1;
          timer_val  = TIMER_W'(DEATH_FRAMES);
          if (lives_q != '0) begin
            lives_d = lives_q - 1'b1;
          end
        end else if (row == '0) begin
          state_d    = ST_GOAL;
          timer_load = 1'b1;
          timer_val  = TIMER_W'(WIN_FRAMES);
          score_d    = score_add(score_q, SCORE_W'(GOAL_POINTS), SCORE_W'(SCORE_MAX));
          if (level_q != LEVEL_W'(LEVEL_MAX)) begin
            level_d = level_q + 1'b1;
          end
        end else if (row < best_row_q) begin
          score_d    = score_add(score_q, SCORE_W'(ROW_POINTS), SCORE_W'(SCORE_MAX));
          best_row_d = row;
        end
      end

      ST_DYING: begin
        if (timer_zero) begin
          state_d = (lives_q == '0) ? ST_GAME_OVER : ST_RESPAWN;
        end
      end

      ST_GOAL: begin
        if (timer_zero) begin
          state_d = ST_RESPAWN;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      outs_q     <= state_outputs(ST_IDLE);
      lives_q    <= '0;
      score_q    <= '0;
      level_q    <= LEVEL_W'(1);
      best_row_q <= ROW_W'(START_ROW);
      start_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      // Outputs are decoded from the next state so they line up with game_state.
      outs_q     <= state_outputs(state_d);
      lives_q    <= lives_d;
      score_q    <= score_d;
      level_q    <= level_d;
      best_row_q <= best_row_d;
      start_q    <= bus.start_btn;
    end
  end

  assign bus.game_state  = state_q;
  assign bus.frog_reset  = outs_q.frog_reset;
  assign bus.move_enable = outs_q.move_enable;
  assign bus.death_anim  = outs_q.death_anim;
  assign bus.lives       = lives_q;
  assign bus.score       = score_q;
  assign bus.level       = level_q;

endmodule

// File: tb/tb_frog_game_ctrl.sv
// Self-checking bench for frog_game_ctrl: a rules-level game model checked every cycle,
// plus directed scenarios with hand-computed score/lives/level/state values.
module tb_frog_game_ctrl;
  import frog_game_pkg::*;

  logic clk = 1'b0;
  logic reset;
  bit   cmp_en = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  frog_game_ctrl_if bus ();

  frog_game_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // ---------------- game model ----------------
  // Modes use the HUD numbering: 0 idle, 1 respawn, 2 play, 3 dying, 4 goal, 5 game over.
  int m_mode   = 0;
  int m_lives  = 0;
  int m_score  = 0;
  int m_level  = 1;
  int m_best   = 14;
  int m_frames = 0;
  bit m_prev_start = 1'b0;

  function automatic int clamp(int v, int hi);
    return (v > hi) ? hi : v;
  endfunction

  always @(posedge clk or posedge reset) begin : model
    int  r;
    bit  pressed;
    if (reset) begin
      m_mode = 0; m_lives = 0; m_score = 0; m_level = 1;
      m_best = 14; m_frames = 0; m_prev_start = 1'b0;
    end else begin
      pressed      = bus.start_btn && !m_prev_start;
      m_prev_start = bus.start_btn;
      r            = (int'(bus.frog_y) / 32) % 16;
      if (m_mode == 0 || m_mode == 5) begin
        if (pressed) begin
          m_mode = 1; m_lives = 3; m_score = 0; m_level = 1;
        end
      end else if (m_mode == 1) begin
        m_best = 14;
        m_mode = 2;
      end else if (m_mode == 2) begin
        if (bus.collision) begin
          m_lives  = m_lives - 1;
          m_frames = 60;
          m_mode   = 3;
        end else if (r == 0) begin
          m_score  = clamp(m_score + 50, 9999);
          m_level  = clamp(m_level + 1, 15);
          m_frames = 90;
          m_mode   = 4;
        end else if (r < m_best) begin
          m_score = clamp(m_score + 10, 9999);
          m_best  = r;
        end
      end else begin
        // dying or goal: wait out the frame budget
        if (m_frames == 0) begin
          m_mode = (m_mode == 3 && m_lives == 0) ? 5 : 1;
        end else if (bus.frame_tick) begin
          m_frames = m_frames - 1;
        end
      end
    end
  end

  // ---------------- checking ----------------
  task automatic check(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_state",       int'(bus.game_state),  m_mode);
      check("cyc_frog_reset",  int'(bus.frog_reset),  int'(m_mode == 0 || m_mode == 1 || m_mode == 5));
      check("cyc_move_enable", int'(bus.move_enable), int'(m_mode == 2));
      check("cyc_death_anim",  int'(bus.death_anim),  int'(m_mode == 3));
      check("cyc_lives",       int'(bus.lives),       m_lives);
      check("cyc_score",       int'(bus.score),       m_score);
      check("cyc_level",       int'(bus.level),       m_level);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) begin
      bus.frame_tick = 1'b1;
      step(1);
      bus.frame_tick = 1'b0;
      step(1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.frame_tick = 1'b0;
    bus.start_btn  = 1'b0;
    bus.collision  = 1'b0;
    bus.frog_y     = 10'(START_Y);
    reset          = 1'b1;
    step(3);
    reset  = 1'b0;
    cmp_en = 1'b1;

    // Reset values
    check("rst_state",      int'(bus.game_state),  0);
    check("rst_frog_reset", int'(bus.frog_reset),  1);
    check("rst_move",       int'(bus.move_enable), 0);
    check("rst_lives",      int'(bus.lives),       0);
    check("rst_score",      int'(bus.score),       0);
    check("rst_level",      int'(bus.level),       1);
    step(2);

    // 1: start -> one RESPAWN cycle -> PLAY
    bus.start_btn = 1'b1;
    step(1);
    check("t1_respawn",    int'(bus.game_state), 1);
    check("t1_frog_reset", int'(bus.frog_reset), 1);
    step(1);
    check("t1_play",  int'(bus.game_state),  2);
    check("t1_move",  int'(bus.move_enable), 1);
    check("t1_lives", int'(bus.lives),       3);
    check("t1_level", int'(bus.level),       1);
    // start presses during PLAY are ignored
    bus.start_btn = 1'b0;
    step(1);
    bus.start_btn = 1'b1;
    step(1);
    bus.start_btn = 1'b0;
    check("t1_start_ignored", int'(bus.game_state), 2);

    // 2: row scoring, no re-score on revisit
    bus.frog_y = 10'd416; step(1);
    check("t2_score_a", int'(bus.score), 10);
    check("t2_model_a", m_score, 10);
    bus.frog_y = 10'd384; step(1);
    check("t2_score_b", int'(bus.score), 20);
    bus.frog_y = 10'd416; step(2);
    check("t2_score_c", int'(bus.score), 20);

    // 3: held collision costs one life
    bus.collision = 1'b1; step(1);
    check("t3_dying", int'(bus.game_state),  3);
    check("t3_lives", int'(bus.lives),       2);
    check("t3_anim",  int'(bus.death_anim),  1);
    check("t3_move",  int'(bus.move_enable), 0);
    step(199);
    bus.collision = 1'b0;
    bus.frog_y    = 10'(START_Y);
    check("t3_lives_held", int'(bus.lives), 2);
    ticks(60);
    check("t3_respawn",    int'(bus.game_state), 1);
    check("t3_frog_reset", int'(bus.frog_reset), 1);
    step(1);
    check("t3_play", int'(bus.game_state), 2);

    // 4: collision on goal row wins; entry-cycle tick not counted
    bus.collision  = 1'b1;
    bus.frog_y     = 10'd0;
    bus.frame_tick = 1'b1;
    step(1);
    bus.collision  = 1'b0;
    bus.frog_y     = 10'(START_Y);
    bus.frame_tick = 1'b0;
    check("t4_dying", int'(bus.game_state), 3);
    check("t4_lives", int'(bus.lives),      1);
    check("t4_score", int'(bus.score),      20);
    check("t4_level", int'(bus.level),      1);
    ticks(59);
    check("t4_still_dying", int'(bus.game_state), 3);
    ticks(1);
    check("t4_respawn", int'(bus.game_state), 1);
    step(1);

    // 5: goal
    bus.frog_y = 10'd416; step(1);
    check("t5_row_a", int'(bus.score), 30);
    bus.frog_y = 10'd384; step(1);
    check("t5_row_b", int'(bus.score), 40);
    bus.frog_y = 10'd0; step(1);
    bus.frog_y = 10'(START_Y);
    check("t5_goal",  int'(bus.game_state),  4);
    check("t5_score", int'(bus.score),       90);
    check("t5_level", int'(bus.level),       2);
    check("t5_move",  int'(bus.move_enable), 0);
    check("t5_model_level", m_level, 2);
    ticks(90);
    check("t5_respawn", int'(bus.game_state), 1);
    step(1);
    bus.frog_y = 10'd416; step(1);
    check("t5_best_row_reset", int'(bus.score), 100);

    // 6: last life -> GAME_OVER, restart, reset mid-DYING
    bus.collision = 1'b1; step(1);
    bus.collision = 1'b0;
    bus.frog_y    = 10'(START_Y);
    check("t6_dying", int'(bus.game_state), 3);
    check("t6_lives", int'(bus.lives),      0);
    ticks(60);
    check("t6_game_over",  int'(bus.game_state), 5);
    check("t6_frog_reset", int'(bus.frog_reset), 1);
    step(5);
    check("t6_hold_state", int'(bus.game_state), 5);
    check("t6_hold_score", int'(bus.score),      100);
    bus.start_btn = 1'b1; step(1);
    check("t6_restart", int'(bus.game_state), 1);
    check("t6_lives3",  int'(bus.lives),      3);
    check("t6_score0",  int'(bus.score),      0);
    check("t6_level1",  int'(bus.level),      1);
    step(1);
    bus.start_btn = 1'b0;
    bus.collision = 1'b1; step(1);
    bus.collision = 1'b0;
    check("t6_dying2", int'(bus.lives), 2);
    ticks(10);
    reset = 1'b1;
    #1;
    check("t6_async_state", int'(bus.game_state), 0);
    check("t6_async_lives", int'(bus.lives),      0);
    step(1);
    check("t6_rst_frog_reset", int'(bus.frog_reset), 1);
    check("t6_rst_anim",       int'(bus.death_anim), 0);
    check("t6_rst_level",      int'(bus.level),      1);
    reset = 1'b0;
    step(3);
    check("t6_idle_after", int'(bus.game_state), 0);

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
